// File: rtl/blake2b_pkg.sv
// Shared definitions for the BLAKE2b front-end blocks.
//   BLAKE2B_BLOCK_BYTS : bytes per compression block
//   packer_state_e     : message packer states (FILL, DROP, SEND)
package blake2b_pkg;

  localparam int BLAKE2B_BLOCK_BYTS = 128;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DROP = 2'd1,
    SEND = 2'd2
  } packer_state_e;

endpackage

// File: rtl/blake2b_byte_merge.sv
// Combinational byte writer: places the first nbytes bytes of an IN_BYTS
// wide beat into a BUF_BYTS wide buffer image starting at byte offset.
// Bytes outside the written window pass through from base.
//   base    : current buffer image
//   offset  : destination byte offset of beat byte 0
//   dat     : beat data, byte 0 in bits [7:0]
//   nbytes  : number of beat bytes to write (1..IN_BYTS)
//   merged  : updated buffer image
module blake2b_byte_merge #(
  parameter int IN_BYTS  = 8,
  parameter int BUF_BYTS = 256,
  parameter int OFF_W    = 9,
  parameter int NB_W     = 4
) (
  input  logic [BUF_BYTS*8-1:0] base,
  input  logic [OFF_W-1:0]      offset,
  input  logic [IN_BYTS*8-1:0]  dat,
  input  logic [NB_W-1:0]       nbytes,
  output logic [BUF_BYTS*8-1:0] merged
);

  localparam int IDX_W = $clog2(BUF_BYTS * 8);

  // Writes that would land past the buffer end are suppressed; the packer
  // never issues them, the guard only keeps the indexing in range.
  always_comb begin
    merged = base;
    for (int k = 0; k < IN_BYTS; k++) begin
      if ((k < int'(nbytes)) && ((int'(offset) + k) < BUF_BYTS)) begin
        merged[IDX_W'((int'(offset) + k) * 8) +: 8] = dat[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/blake2b_msg_packer.sv
// BLAKE2b message packer. Collects one framed little-endian byte stream
// message (up to MAX_BLOCKS*128 bytes), zero-pads it and replays it as
// 128-byte block beats with the total length held for the whole frame.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_dat/i_val/i_sop/i_eop/i_mod, o_rdy : input beat stream
//   o_dat/o_val/o_sop/o_eop/o_mod, i_rdy : output block stream
//   o_byte_len            : message length, valid for the whole output frame
//   o_drop                : one-cycle pulse when an oversized message is discarded
//   o_msg_cnt/o_drop_cnt  : statistics, live only with BLAKE2B_PACKER_STATS_EN
// Optional feature macro: BLAKE2B_PACKER_STATS_EN
module blake2b_msg_packer
  import blake2b_pkg::*;
#(
  parameter int IN_BYTS    = 8,
  parameter int MAX_BLOCKS = 2,
  parameter int LEN_BITS   = 8,
  localparam int MOD_W     = (IN_BYTS > 1) ? $clog2(IN_BYTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IN_BYTS*8-1:0]  i_dat,
  input  logic                  i_val,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic [MOD_W-1:0]      i_mod,
  output logic                  o_rdy,
  output logic [1023:0]         o_dat,
  output logic                  o_val,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [6:0]            o_mod,
  input  logic                  i_rdy,
  output logic [LEN_BITS-1:0]   o_byte_len,
  output logic                  o_drop,
  output logic [31:0]           o_msg_cnt,
  output logic [31:0]           o_drop_cnt
);

  localparam int CAP   = MAX_BLOCKS * BLAKE2B_BLOCK_BYTS;
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int NB_W  = $clog2(IN_BYTS + 1);
  localparam int BLK_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

  packer_state_e       state, state_nxt;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_nxt;
  logic [CAP*8-1:0]    buffer, merged, merge_base;
  logic [BLK_W-1:0]    blk, last_blk;
  logic [6:0]          msg_mod;
  logic [NB_W-1:0]     beat_bytes;
  logic [CNT_W-1:0]    write_off;
  logic [CNT_W:0]      sum;
  logic                overflow;
  logic                in_xfer, out_xfer;
  logic                buf_load, len_load, drop_set;

  assign in_xfer  = i_val & o_rdy;
  assign out_xfer = o_val & i_rdy;

  // A short eop beat carries i_mod bytes; zero there means a full beat.
  assign beat_bytes = (i_eop && (i_mod != '0)) ? NB_W'(i_mod) : NB_W'(IN_BYTS);
  assign write_off  = i_sop ? '0 : byte_cnt;
  assign sum        = (CNT_W+1)'(write_off) + (CNT_W+1)'(beat_bytes);
  assign overflow   = sum > (CNT_W+1)'(CAP);

  // A sop beat starts from an all-zero image so the tail padding is zero.
  assign merge_base = i_sop ? '0 : buffer;

  blake2b_byte_merge #(
    .IN_BYTS  (IN_BYTS),
    .BUF_BYTS (CAP),
    .OFF_W    (CNT_W),
    .NB_W     (NB_W)
  ) u_merge (
    .base   (merge_base),
    .offset (write_off),
    .dat    (i_dat),
    .nbytes (beat_bytes),
    .merged (merged)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= FILL;
    else       state <= state_nxt;
  end

  // A sop beat restarts the message from either FILL or DROP; leaving DROP
  // this way still reports the discarded message.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    buf_load     = 1'b0;
    len_load     = 1'b0;
    drop_set     = 1'b0;
    case (state)
      FILL, DROP: begin
        if (in_xfer) begin
          if (i_sop) begin
            buf_load     = 1'b1;
            byte_cnt_nxt = sum[CNT_W-1:0];
            drop_set     = (state == DROP);
            state_nxt    = FILL;
            if (i_eop) begin
              len_load  = 1'b1;
              state_nxt = SEND;
            end
          end else if (state == DROP) begin
            if (i_eop) begin
              drop_set     = 1'b1;
              byte_cnt_nxt = '0;
              state_nxt    = FILL;
            end
          end else if (byte_cnt != '0) begin
            if (overflow) begin
              byte_cnt_nxt = '0;
              if (i_eop) drop_set = 1'b1;
              else       state_nxt = DROP;
            end else begin
              buf_load     = 1'b1;
              byte_cnt_nxt = sum[CNT_W-1:0];
              if (i_eop) begin
                len_load  = 1'b1;
                state_nxt = SEND;
              end
            end
          end
        end
      end
      SEND: begin
        if (out_xfer && (blk == last_blk)) begin
          byte_cnt_nxt = '0;
          state_nxt    = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // The frame length, last block index and tail count are captured on the
  // eop beat and stay frozen while the blocks drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buffer     <= '0;
      byte_cnt   <= '0;
      blk        <= '0;
      last_blk   <= '0;
      msg_mod    <= '0;
      o_byte_len <= '0;
      o_drop     <= 1'b0;
    end else begin
      byte_cnt <= byte_cnt_nxt;
      o_drop   <= drop_set;
      if (buf_load) buffer <= merged;
      if (len_load) begin
        o_byte_len <= LEN_BITS'(sum);
        msg_mod    <= sum[6:0];
        last_blk   <= BLK_W'((sum - (CNT_W+1)'(1)) >> 7);
        blk        <= '0;
      end else if (out_xfer) begin
        blk <= (blk == last_blk) ? '0 : blk + BLK_W'(1);
      end
    end
  end

  assign o_rdy = (state != SEND);
  assign o_val = (state == SEND);
  assign o_sop = o_val && (blk == '0);
  assign o_eop = o_val && (blk == last_blk);
  assign o_mod = o_eop ? msg_mod : 7'd0;

  always_comb begin
    o_dat = '0;
    for (int b = 0; b < MAX_BLOCKS; b++) begin
      if (blk == BLK_W'(b)) o_dat = buffer[b*1024 +: 1024];
    end
  end

`ifdef BLAKE2B_PACKER_STATS_EN
  logic [31:0] msg_cnt, drop_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      msg_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_xfer && o_eop) msg_cnt <= msg_cnt + 32'd1;
      if (drop_set)          drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign o_msg_cnt  = msg_cnt;
  assign o_drop_cnt = drop_cnt;
`else
  assign o_msg_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_blake2b_msg_packer.sv
// Scoreboard bench for blake2b_msg_packer: a byte-queue message model
// predicts block beats and drop pulses, a monitor compares them as the
// DUT presents them.
module tb_blake2b_msg_packer;

  localparam int IN_BYTS    = 8;
  localparam int MAX_BLOCKS = 2;
  localparam int LEN_BITS   = 8;
  localparam int CAP        = MAX_BLOCKS * 128;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [63:0]   i_dat;
  logic          i_val, i_sop, i_eop;
  logic [2:0]    i_mod;
  logic          o_rdy;
  logic [1023:0] o_dat;
  logic          o_val, o_sop, o_eop;
  logic [6:0]    o_mod;
  logic          i_rdy;
  logic [7:0]    o_byte_len;
  logic          o_drop;
  logic [31:0]   o_msg_cnt, o_drop_cnt;

  blake2b_msg_packer #(
    .IN_BYTS(IN_BYTS), .MAX_BLOCKS(MAX_BLOCKS), .LEN_BITS(LEN_BITS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_dat), .i_val(i_val),
    .i_sop(i_sop), .i_eop(i_eop), .i_mod(i_mod), .o_rdy(o_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop),
    .o_mod(o_mod), .i_rdy(i_rdy), .o_byte_len(o_byte_len),
    .o_drop(o_drop), .o_msg_cnt(o_msg_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit            is_drop;
    logic [1023:0] dat;
    bit            sop;
    bit            eop;
    logic [6:0]    mdo;
    logic [7:0]    len;
  } exp_t;

  exp_t         exp_q[$];
  byte unsigned cur[$];
  bit           in_drop = 1'b0;
  int           model_msgs = 0;
  int           model_drops = 0;
  int           checks = 0;
  int           errors = 0;
  int           rdy_mode = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic checkBlock(input string name, input logic [1023:0] act, input logic [1023:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      for (int i = 0; i < 128; i++) begin
        if (act[i*8 +: 8] !== req[i*8 +: 8]) begin
          $display("[TB] FAIL %s: byte %0d got %h expected %h", name, i, act[i*8 +: 8], req[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  task automatic pushDrop();
    exp_t e;
    e = '{is_drop: 1'b1, dat: '0, sop: 1'b0, eop: 1'b0, mdo: '0, len: '0};
    exp_q.push_back(e);
    model_drops++;
  endtask

  // A finished message becomes ceil(len/128) zero-padded blocks.
  task automatic emitMsg();
    int   len, nblk;
    exp_t e;
    len  = cur.size();
    nblk = (len + 127) / 128;
    for (int b = 0; b < nblk; b++) begin
      e.is_drop = 1'b0;
      e.dat     = '0;
      for (int i = 0; i < 128; i++)
        if (b*128 + i < len) e.dat[i*8 +: 8] = cur[b*128 + i];
      e.sop = (b == 0);
      e.eop = (b == nblk - 1);
      e.mdo = (b == nblk - 1) ? 7'(len % 128) : 7'd0;
      e.len = 8'(len);
      exp_q.push_back(e);
    end
    model_msgs++;
    cur.delete();
  endtask

  task automatic modelBeat(input logic [63:0] dat, input bit sop, input bit eop, input int n);
    if (sop) begin
      if (in_drop) pushDrop();
      in_drop = 1'b0;
      cur.delete();
    end else if (in_drop) begin
      if (eop) begin
        pushDrop();
        in_drop = 1'b0;
      end
      return;
    end else if (cur.size() == 0) begin
      return;
    end else if (cur.size() + n > CAP) begin
      cur.delete();
      if (eop) pushDrop();
      else     in_drop = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) cur.push_back(dat[i*8 +: 8]);
    if (eop) emitMsg();
  endtask

  task automatic sendBeat(input logic [63:0] dat, input bit sop, input bit eop, input int mdo);
    int waited;
    waited = 0;
    @(negedge i_clk);
    while (!o_rdy) begin
      waited++;
      if (waited > 2000) begin
        checkOutput("rdy_timeout", 64'(o_rdy), 64'd1);
        return;
      end
      @(negedge i_clk);
    end
    i_val = 1'b1; i_dat = dat; i_sop = sop; i_eop = eop; i_mod = 3'(mdo);
    modelBeat(dat, sop, eop, (eop && mdo != 0) ? mdo : IN_BYTS);
    @(posedge i_clk);
    #1;
    i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  // Sends a len-byte message of random bytes; with_eop=0 leaves it open.
  task automatic applyStimulus(input int len, input bit with_eop);
    int nb;
    nb = (len + IN_BYTS - 1) / IN_BYTS;
    for (int b = 0; b < nb; b++) begin
      bit last;
      last = with_eop && (b == nb - 1);
      sendBeat({$urandom, $urandom}, b == 0, last, last ? (len % IN_BYTS) : 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_val) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic checkCounters(input string tag);
`ifdef BLAKE2B_PACKER_STATS_EN
    checkOutput({tag, "_msg_cnt"}, 64'(o_msg_cnt), 64'(model_msgs));
    checkOutput({tag, "_drop_cnt"}, 64'(o_drop_cnt), 64'(model_drops));
`else
    checkOutput({tag, "_msg_cnt_tied"}, 64'(o_msg_cnt), 64'd0);
    checkOutput({tag, "_drop_cnt_tied"}, 64'(o_drop_cnt), 64'd0);
`endif
  endtask

  // Monitor: picks the downstream ready for the coming edge, then checks
  // whatever the DUT presents against the head of the scoreboard.
  initial begin
    i_rdy = 1'b1;
    forever begin
      @(negedge i_clk);
      case (rdy_mode)
        0:       i_rdy = 1'b1;
        1:       i_rdy = 1'($urandom_range(0, 1));
        2:       i_rdy = ~i_rdy;
        default: i_rdy = 1'b0;
      endcase
      if (!i_rst) begin
        if (o_drop) begin
          if (exp_q.size() == 0) checkOutput("drop_unexpected", 64'd1, 64'd0);
          else begin
            checkOutput("drop_in_order", 64'd1, 64'(exp_q[0].is_drop));
            if (exp_q[0].is_drop) void'(exp_q.pop_front());
          end
        end
        if (o_val) begin
          if (exp_q.size() == 0 || exp_q[0].is_drop) begin
            checkOutput("val_unexpected", 64'd1, 64'd0);
          end else begin
            checkBlock("blk_dat", o_dat, exp_q[0].dat);
            checkOutput("blk_sop", 64'(o_sop), 64'(exp_q[0].sop));
            checkOutput("blk_eop", 64'(o_eop), 64'(exp_q[0].eop));
            checkOutput("blk_mod", 64'(o_mod), 64'(exp_q[0].mdo));
            checkOutput("blk_len", 64'(o_byte_len), 64'(exp_q[0].len));
            if (i_rdy) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_mod = '0; i_dat = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_rdy", 64'(o_rdy), 64'd1);
    checkOutput("rst_val", 64'(o_val), 64'd0);
    checkOutput("rst_sop_eop", 64'({o_sop, o_eop}), 64'd0);
    checkOutput("rst_drop", 64'(o_drop), 64'd0);
    checkOutput("rst_mod", 64'(o_mod), 64'd0);
    checkOutput("rst_len", 64'(o_byte_len), 64'd0);
    checkBlock("rst_dat", o_dat, '0);
    checkCounters("rst");
    i_rst = 1'b0;

    $display("[TB] abc single beat");
    sendBeat({40'hA5A5A5A5A5, 24'h636261}, 1'b1, 1'b1, 3);
    @(negedge i_clk);
    checkOutput("abc_latency_val", 64'(o_val), 64'd1);
    checkOutput("abc_dat_lo", o_dat[63:0], 64'h636261);
    checkOutput("abc_dat_hi_zero", 64'(|o_dat[1023:64]), 64'd0);
    checkOutput("abc_len", 64'(o_byte_len), 64'd3);
    drain();

    $display("[TB] 128 bytes");
    applyStimulus(128, 1'b1);
    drain();

    $display("[TB] 140 bytes with toggling ready");
    rdy_mode = 2;
    applyStimulus(140, 1'b1);
    drain();
    rdy_mode = 0;

    $display("[TB] 264 byte overflow");
    applyStimulus(264, 1'b1);
    @(negedge i_clk);
    checkOutput("ovf_drop_pulse", 64'(o_drop), 64'd1);
    checkOutput("ovf_no_val", 64'(o_val), 64'd0);
    checkOutput("ovf_rdy", 64'(o_rdy), 64'd1);
    applyStimulus(3, 1'b1);
    drain();

    $display("[TB] sop restart after 40 bytes");
    applyStimulus(40, 1'b0);
    applyStimulus(5, 1'b1);
    drain();

    $display("[TB] stray beat while idle");
    sendBeat({$urandom, $urandom}, 1'b0, 1'b1, 0);
    drain();
    checkCounters("directed");

    $display("[TB] random traffic");
    rdy_mode = 1;
    for (int it = 0; it < 60; it++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 300);
      if (kind == 0)      applyStimulus(len, 1'b0);
      else if (kind == 1) sendBeat({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      else                applyStimulus(len, 1'b1);
    end
    applyStimulus(17, 1'b1);
    drain();
    checkCounters("random");

    $display("[TB] reset during first block");
    rdy_mode = 3;
    applyStimulus(140, 1'b1);
    @(negedge i_clk);
    checkOutput("pre_rst_val", 64'(o_val), 64'd1);
    #1 i_rst = 1'b1;
    #1;
    checkOutput("midrst_val", 64'(o_val), 64'd0);
    checkOutput("midrst_rdy", 64'(o_rdy), 64'd1);
    exp_q.delete();
    cur.delete();
    in_drop = 1'b0;
    model_msgs = 0;
    model_drops = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("postrst_rdy", 64'(o_rdy), 64'd1);
    checkCounters("postrst");
    rdy_mode = 0;
    applyStimulus(3, 1'b1);
    drain();
    checkCounters("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
